data_memory: RTL and testbench

DATA_MEMORY -- requirements
Module: data_memory

---
 rtl/data_memory.sv | 96 +++++++++
 tb/tb_data_memory.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/data_memory.sv
// data_memory: byte-addressed little-endian data RAM with sized, signed or
// unsigned loads and byte/halfword/word stores. Addresses and multi-byte
// accesses wrap modulo MEM_BYTES. Loads are registered with one cycle of latency.
module data_memory #(
  parameter int MEM_BYTES = 1024
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        MEM_W_En,
  input  logic [2:0]  MEM_Control,
  input  logic [31:0] RW_Addr,
  input  logic [31:0] W_Data,
  output logic [31:0] Data_Out
);

  localparam int AW = $clog2(MEM_BYTES);

  // Access size/sign encodings shared with the rest of the pipeline.
  localparam logic [2:0] MEM_BYTE              = 3'b000;
  localparam logic [2:0] MEM_HALFWORD          = 3'b001;
  localparam logic [2:0] MEM_WORD              = 3'b010;
  localparam logic [2:0] MEM_BYTE_UNSIGNED     = 3'b100;
  localparam logic [2:0] MEM_HALFWORD_UNSIGNED = 3'b101;

  // Byte storage. It starts out cleared and is never touched by reset.
  logic [7:0] memory [0:MEM_BYTES-1] = '{default: 8'h00};

  logic [AW-1:0] addr_a;
  logic [AW-1:0] byte_addr [4];
  logic [7:0]    rd_byte   [4];
  logic [3:0]    wr_en;
  logic [31:0]   data_out_d;
  logic [31:0]   data_out_q;
  logic          unused_addr;

  // Upper address bits are ignored, so the address wraps modulo MEM_BYTES.
  assign addr_a      = RW_Addr[AW-1:0];
  assign unused_addr = ^RW_Addr[31:AW];

  // Byte lane k addresses A+k. The truncation to AW bits gives the wrap.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign byte_addr[gi] = addr_a + AW'(gi);
    assign rd_byte[gi]   = memory[byte_addr[gi]];
  end

  // Select the byte lanes a store writes. Undefined codes write nothing.
  always_comb begin
    wr_en = 4'b0000;
    if (MEM_W_En) begin
      case (MEM_Control)
        MEM_BYTE, MEM_BYTE_UNSIGNED:         wr_en = 4'b0001;
        MEM_HALFWORD, MEM_HALFWORD_UNSIGNED: wr_en = 4'b0011;
        MEM_WORD:                            wr_en = 4'b1111;
        default:                             wr_en = 4'b0000;
      endcase
    end
  end

  // Form the next load result. Stores hold the previous value, and undefined codes load zero.
  always_comb begin
    data_out_d = data_out_q;
    if (!MEM_W_En) begin
      case (MEM_Control)
        MEM_BYTE:              data_out_d = {{24{rd_byte[0][7]}}, rd_byte[0]};
        MEM_BYTE_UNSIGNED:     data_out_d = {24'h000000, rd_byte[0]};
        MEM_HALFWORD:          data_out_d = {{16{rd_byte[1][7]}}, rd_byte[1], rd_byte[0]};
        MEM_HALFWORD_UNSIGNED: data_out_d = {16'h0000, rd_byte[1], rd_byte[0]};
        MEM_WORD:              data_out_d = {rd_byte[3], rd_byte[2], rd_byte[1], rd_byte[0]};
        default:               data_out_d = 32'h0000_0000;
      endcase
    end
  end

  // Byte-lane writes. These are blocked while reset is held so contents survive it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int k = 0; k < 4; k++) begin
        if (wr_en[k]) begin
          memory[byte_addr[k]] <= W_Data[8*k +: 8];
        end
      end
    end
  end

  // Load result register. Reset clears it at once, so an aborted load never appears.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      data_out_q <= 32'h0000_0000;
    end else begin
      data_out_q <= data_out_d;
    end
  end

  assign Data_Out = data_out_q;

endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory: directed test of data_memory covering sized stores and loads,
// misaligned and wrapping accesses, undefined codes, reset behaviour and a word sweep.
module tb_data_memory;

  localparam int MEM_BYTES = 1024;

  localparam logic [2:0] C_B   = 3'b000;
  localparam logic [2:0] C_H   = 3'b001;
  localparam logic [2:0] C_W   = 3'b010;
  localparam logic [2:0] C_BU  = 3'b100;
  localparam logic [2:0] C_HU  = 3'b101;
  localparam logic [2:0] C_U3  = 3'b011;
  localparam logic [2:0] C_U6  = 3'b110;
  localparam logic [2:0] C_U7  = 3'b111;

  logic        CLK = 1'b0;
  logic        RST;
  logic        MEM_W_En;
  logic [2:0]  MEM_Control;
  logic [31:0] RW_Addr;
  logic [31:0] W_Data;
  logic [31:0] Data_Out;

  int tests  = 0;
  int failed = 0;

  data_memory #(.MEM_BYTES(MEM_BYTES)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .MEM_W_En   (MEM_W_En),
    .MEM_Control(MEM_Control),
    .RW_Addr    (RW_Addr),
    .W_Data     (W_Data),
    .Data_Out   (Data_Out)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One store cycle. Inputs change 1 time unit after the edge, and the task returns 1 unit after the edge that samples them.
  task automatic store(input logic [2:0] c, input logic [31:0] a, input logic [31:0] d);
    MEM_W_En = 1'b1; MEM_Control = c; RW_Addr = a; W_Data = d;
    @(posedge CLK); #1;
    $display("[TB] store ctrl=%b addr=%h data=%h", c, a, d);
  endtask

  task automatic load(input logic [2:0] c, input logic [31:0] a);
    MEM_W_En = 1'b0; MEM_Control = c; RW_Addr = a; W_Data = 32'h0;
    @(posedge CLK); #1;
    $display("[TB] load  ctrl=%b addr=%h -> %h", c, a, Data_Out);
  endtask

  initial begin
    RST = 1'b1; MEM_W_En = 1'b0; MEM_Control = C_W; RW_Addr = 32'h0; W_Data = 32'h0;
    #2 RST = 1'b0;
    #1;
    check("reset_dout", Data_Out, 32'h0);
    check("init_mem0", {24'h0, dut.memory[0]}, 32'h0);

    // A store while reset is held must not write anything.
    store(C_W, 32'h10, 32'h12345678);
    check("rst_store_blocked", {24'h0, dut.memory[16]}, 32'h0);
    check("rst_dout_held", Data_Out, 32'h0);
    RST = 1'b1;

    // Byte, halfword and word stores.
    store(C_B, 32'h0, 32'hFFFFFFFF);
    check("st_b_m0", {24'h0, dut.memory[0]}, 32'hFF);
    check("st_b_m1", {24'h0, dut.memory[1]}, 32'h00);
    check("st_dout_hold", Data_Out, 32'h0);
    store(C_H, 32'h2, 32'hF00FF00F);
    check("st_h_m2", {24'h0, dut.memory[2]}, 32'h0F);
    check("st_h_m3", {24'h0, dut.memory[3]}, 32'hF0);
    check("st_h_m1", {24'h0, dut.memory[1]}, 32'h00);
    store(C_W, 32'h4, 32'hFAAFFAAF);
    check("st_w_m4", {24'h0, dut.memory[4]}, 32'hAF);
    check("st_w_m5", {24'h0, dut.memory[5]}, 32'hFA);
    check("st_w_m6", {24'h0, dut.memory[6]}, 32'hAF);
    check("st_w_m7", {24'h0, dut.memory[7]}, 32'hFA);
    check("st_w_m8", {24'h0, dut.memory[8]}, 32'h00);

    // Sized loads.
    load(C_B, 32'h0);  check("ld_b0",  Data_Out, 32'hFFFFFFFF);
    load(C_BU, 32'h0); check("ld_bu0", Data_Out, 32'h000000FF);
    load(C_H, 32'h2);  check("ld_h2",  Data_Out, 32'hFFFFF00F);
    load(C_HU, 32'h2); check("ld_hu2", Data_Out, 32'h0000F00F);
    load(C_W, 32'h4);  check("ld_w4",  Data_Out, 32'hFAAFFAAF);

    // A store cycle holds Data_Out.
    store(C_B, 32'h20, 32'h00000011);
    check("st_hold_dout", Data_Out, 32'hFAAFFAAF);
    check("st_b_m20", {24'h0, dut.memory[32]}, 32'h11);

    // Undefined codes: a store writes nothing and a load returns zero.
    store(C_U3, 32'h0, 32'h00000000);
    check("undef_st_m0", {24'h0, dut.memory[0]}, 32'hFF);
    load(C_U6, 32'h4); check("undef_ld6", Data_Out, 32'h0);
    load(C_W, 32'h4);
    load(C_U7, 32'h4); check("undef_ld7", Data_Out, 32'h0);

    // Misaligned access, ignored upper address bits, and store-then-load.
    load(C_W, 32'h3);          check("ld_w_mis3", Data_Out, 32'hAFFAAFF0);
    load(C_W, 32'h8000_0404);  check("ld_w_hiaddr", Data_Out, 32'hFAAFFAAF);
    store(C_H, 32'h30, 32'hABCD1234);
    load(C_H, 32'h30);         check("raw_h30", Data_Out, 32'h00001234);
    load(C_B, 32'h31);         check("ld_b31_pos", Data_Out, 32'h00000012);

    // Reset in mid-cycle clears the output at once and aborts the pending load.
    load(C_W, 32'h4); check("pre_rst_w4", Data_Out, 32'hFAAFFAAF);
    MEM_Control = C_W; RW_Addr = 32'h4; MEM_W_En = 1'b0;
    #2 RST = 1'b0;
    #1 check("rst_async_clr", Data_Out, 32'h0);
    @(posedge CLK); #1;
    check("rst_abort_load", Data_Out, 32'h0);
    RST = 1'b1;
    load(C_W, 32'h4); check("post_rst_w4", Data_Out, 32'hFAAFFAAF);

    // A word access that wraps past the top of memory.
    store(C_W, MEM_BYTES - 2, 32'hA1B2C3D4);
    check("wrap_m0", {24'h0, dut.memory[0]}, 32'hB2);
    check("wrap_m1023", {24'h0, dut.memory[MEM_BYTES-1]}, 32'hC3);
    load(C_W, MEM_BYTES - 2);  check("wrap_ld_w", Data_Out, 32'hA1B2C3D4);
    load(C_HU, MEM_BYTES - 1); check("wrap_ld_hu", Data_Out, 32'h0000B2C3);

    // Word sweep: store back-to-back, then read every word back.
    for (int i = 0; i < 256; i += 4) store(C_W, i, i);
    for (int i = 0; i < 256; i += 4) begin
      load(C_W, i);
      check($sformatf("sweep_%0d", i), Data_Out, i);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
